// File: rtl/shift_seq_pkg.sv
// Purpose: shared state encoding and defaults for the serial shift sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_seq_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic [1:0] ST_IDLE_ENC  = 2'b00;
    localparam logic [1:0] ST_SHIFT_ENC = 2'b01;
    localparam logic [1:0] ST_DONE_ENC  = 2'b10;

    // 2'b11 is unused and decodes back to IDLE in the controller.
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE_ENC,
        SHIFT = ST_SHIFT_ENC,
        DONE  = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/shift_reg_n.sv
// Purpose: WIDTH-bit register with parallel load and right shift (LSB out, msb_in enters at top).
// Latency: load/shift visible on q one clock after the enabling edge.
// Backpressure: none; shift_en low simply holds contents.
module shift_reg_n
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             shift_en,
    input  logic             msb_in,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    // Load wins over shift; the controller never asserts both in one cycle.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift_en) begin
            q <= {msb_in, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Purpose: load/shift/count sequencer for a serial shift register; ROTATE_EN feeds reg[0] back into the MSB.
// Latency: start at edge t -> bits valid cycles t+1..t+WIDTH, done at t+WIDTH+1; each hold cycle adds one.
// Backpressure: hold stalls shifting and counting in SHIFT; start is ignored unless IDLE.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    input  logic             hold,
    output logic             busy,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] par_out
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count_nxt;
    logic             load;
    logic             shift_en;
    logic             msb_in;
    logic [WIDTH-1:0] sreg;

`ifdef ROTATE_EN
    // Rotation: the bit leaving at the bottom re-enters at the top, sin is not used.
    logic unused_sin;
    assign unused_sin = sin;
    assign msb_in     = sreg[0];
`else
    assign msb_in = sin;
`endif

    shift_reg_n #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clock    (clock),
        .clear    (clear),
        .load     (load),
        .shift_en (shift_en),
        .msb_in   (msb_in),
        .din      (din),
        .q        (sreg)
    );

    // State and shift counter registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Next state, counter update and register load/shift strobes.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        load      = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    count_nxt = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!hold) begin
                    shift_en = 1'b1;
                    if (count == LAST) begin
                        count_nxt = '0;
                        state_nxt = DONE;
                    end else begin
                        count_nxt = count + CW'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decodes; sout_valid marks the edges on which a bit actually leaves.
    always_comb begin
        busy       = (state == SHIFT);
        done       = (state == DONE);
        sout_valid = (state == SHIFT) && !hold;
        sout       = sreg[0];
        par_out    = sreg;
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Purpose: randomized scoreboard bench for shift_seq_ctrl (honours ROTATE_EN when defined).
// Latency: expected bit and done entries are queued at the accepted start edge.
// Backpressure: hold patterns are pre-planned per transfer so done timing is known up front.
module tb_shift_seq_ctrl;

    localparam int W  = 4;
    localparam int CW = $clog2(W);

    logic          clock;
    logic          clear;
    logic          start;
    logic [W-1:0]  din;
    logic          sin;
    logic          hold;
    logic          busy;
    logic          sout;
    logic          sout_valid;
    logic          done;
    logic [CW-1:0] count;
    logic [W-1:0]  par_out;

    typedef struct {
        logic b;
        int   idx;
    } bit_exp_t;

    typedef struct {
        int           cyc;
        logic [W-1:0] par;
    } done_exp_t;

    bit_exp_t  bq[$];
    done_exp_t dq[$];

    int tests;
    int fails;
    int cyc;

    shift_seq_ctrl #(
        .WIDTH (W)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .din        (din),
        .sin        (sin),
        .hold       (hold),
        .busy       (busy),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done),
        .count      (count),
        .par_out    (par_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented bit and done pulse against the queues.
    always @(negedge clock) begin
        if (clear === 1'b1) begin
            chk("done_busy_exclusive", {31'd0, done & busy}, 32'd0);
            if (busy) begin
                if (bq.size() == 0) begin
                    chk("busy_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("count", 32'(count), 32'(bq[0].idx));
                end
            end
            if (sout_valid) begin
                if (bq.size() == 0) begin
                    chk("sout_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    bit_exp_t e;
                    e = bq.pop_front();
                    chk("sout", {31'd0, sout}, {31'd0, e.b});
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    done_exp_t e;
                    e = dq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("par_out_at_done", 32'(par_out), 32'(e.par));
                end
            end
        end
    end

    // Drives start/din during non-IDLE cycles; the DUT must ignore these.
    task automatic spur_drive(input int spur);
        if (spur == 1) begin
            start = 1'b1;
            din   = 4'b0110;
        end else if (spur == 2) begin
            start = 1'($urandom_range(0, 1));
            din   = W'($urandom);
        end else begin
            start = 1'b0;
        end
    endtask

    // Model: W bits LSB-first, done W+holds cycles after the start edge, final
    // contents are the constant fill bit replicated (or din itself when rotating).
    task automatic issue(input logic [W-1:0] d, input logic s, input int hmode, input int nh_out[W]);
        int           nh;
        int           st;
        logic [W-1:0] exp_par;
        nh = 0;
        for (int k = 0; k < W; k++) nh += nh_out[k];
`ifdef ROTATE_EN
        exp_par = d;
`else
        exp_par = {W{s}};
`endif
        din   = d;
        sin   = s;
        start = 1'b1;
        hold  = 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
        st = cyc;
        for (int k = 0; k < W; k++) bq.push_back('{b: d[k], idx: k});
        dq.push_back('{cyc: st + W + nh, par: exp_par});
        start = 1'b0;
        hold  = 1'b0;
        if (hmode < 0) nh = 0;
    endtask

    task automatic transfer(input logic [W-1:0] d, input logic s, input int hmode, input int spur);
        int hb[W];
        for (int k = 0; k < W; k++) begin
            if (hmode == 2)
                hb[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            else if (hmode == 1 && k == 2)
                hb[k] = 2;
            else
                hb[k] = 0;
        end
        issue(d, s, hmode, hb);
        for (int k = 0; k < W; k++) begin
            repeat (hb[k]) begin
                hold = 1'b1;
                spur_drive(spur);
                @(posedge clock);
                #1;
            end
            hold = 1'b0;
            spur_drive(spur);
            @(posedge clock);
            #1;
        end
        hold = 1'($urandom_range(0, 1));
        spur_drive(spur);
        @(posedge clock);
        #1;
        start = 1'b0;
        hold  = 1'b0;
    endtask

    task automatic abort_after_two(input logic [W-1:0] d);
        int hb[W];
        for (int k = 0; k < W; k++) hb[k] = 0;
        issue(d, 1'b0, 0, hb);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        bq.delete();
        dq.delete();
        clear = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_par_out", 32'(par_out), 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sout_valid", {31'd0, sout_valid}, 32'd0);
        @(posedge clock);
        #1;
        clear = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        clear = 1'b0;
        start = 1'b0;
        din   = '0;
        sin   = 1'b0;
        hold  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_sout", {31'd0, sout}, 32'd0);
        chk("reset_sout_valid", {31'd0, sout_valid}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_par_out", 32'(par_out), 32'd0);
        clear = 1'b1;
        @(posedge clock);
        #1;

        transfer(4'b1101, 1'b0, 0, 0);
        transfer(4'b1001, 1'b0, 1, 0);
        transfer(4'b1010, 1'b0, 0, 1);
        abort_after_two(4'b1101);
        transfer(4'b1101, 1'b0, 0, 0);
        transfer(4'b0000, 1'b1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            transfer(W'($urandom), 1'($urandom_range(0, 1)), 2, 2);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clock);
                    #1;
                end
            end
        end

        repeat (3) @(posedge clock);
        #1;
        chk("bits_drained", 32'(bq.size()), 32'd0);
        chk("dones_drained", 32'(dq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencing controller for an N-bit serial shift register.
- Accepts a parallel word on a start pulse.
- Shifts the word out LSB-first, one bit per clock, over exactly WIDTH enabled cycles, with a hold (stall) input.
- Flags completion with a one-cycle done pulse.
- Sits between a parallel producer and a serial consumer, and owns the register's load/shift/count sequencing.

Parameters:
- WIDTH, 4, register width and number of shifts per transfer; legal range ≥ 2.
- CW, $clog2(WIDTH), shift counter width (derived; not overridden).

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  transfer request; sampled only in IDLE.
- din  in  WIDTH  parallel word, captured on the accepted start edge.
- sin  in  1  serial fill bit entering the MSB on each shift.
- hold  in  1  stalls shifting and counting while high, in SHIFT only.
- busy  out  1  high in the SHIFT state.
- sout  out  1  current serial bit, equal to reg[0].
- sout_valid  out  1  high in SHIFT when hold=0; the consumer samples sout on that edge.
- done  out  1  one-cycle pulse in the DONE state.
- count  out  CW  number of completed shifts in the current transfer.
- par_out  out  WIDTH  current shift register contents.

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE, reg=0, count=0.
  - busy=0, sout=0, sout_valid=0, done=0, par_out=0.
  - Reset asserted mid-transfer aborts immediately; there is no partial done.
- States: IDLE, SHIFT, DONE (2-bit encoding; unused encoding returns to IDLE).
- IDLE:
  - On start=1 at an edge: reg<=din, count<=0, next=SHIFT.
  - Otherwise reg holds.
- SHIFT:
  - hold=1: reg, count and state hold; sout_valid=0.
  - hold=0: reg<={sin, reg[WIDTH-1:1]}.
    - If count==WIDTH-1: count<=0, next=DONE.
    - Else count<=count+1.
- DONE:
  - done=1 for exactly one cycle; reg holds; next=IDLE unconditionally.
- start outside IDLE is ignored, not queued. start in the DONE cycle is also ignored. The minimum start-to-start spacing is WIDTH+2 cycles.
- Latency with no hold:
  - start sampled at edge t.
  - sout_valid is high during cycles t+1 .. t+WIDTH, carrying din[0] .. din[WIDTH-1].
  - done is high in cycle t+WIDTH+1.
  - busy returns to 0 from cycle t+WIDTH+1.
  - Each hold cycle extends all of these by one cycle.
- Outputs are registered-state decodes. done and busy are never high together.
- din and sin changes outside the capture/shift edges have no effect.

Optional Feature:
- Macro ROTATE_EN.
- Defined: the MSB fill bit is reg[0] instead of sin, so after WIDTH shifts par_out equals the captured din. sin is ignored.
- Undefined: the MSB fills from sin, as specified above.
- Port list is identical in both builds.

Decomposition:
- Package shift_seq_pkg holds:
  - state typedef (IDLE/SHIFT/DONE);
  - encoding constants;
  - default WIDTH constant.
- One natural sub-module, shift_reg_n: a WIDTH-bit register with load, shift_en and msb_in inputs.
- FSM and counter stay in the top.

Test Plan:
1. Reset then basic transfer:
   - Stimulus: clear=0 for 2 cycles, then clear=1; start pulse with din=4'b1101, sin=0, hold=0.
   - Response: sout on the four sout_valid cycles = 1,0,1,1; done pulse in cycle t+5; par_out=4'b0000 afterwards.
2. Hold stall:
   - Stimulus: din=4'b1001; hold=1 for 2 cycles after the second shift.
   - Response: sout_valid low during hold; count stays at 2; done in cycle t+7; bit sequence still 1,0,0,1.
3. Ignored start:
   - Stimulus: re-assert start with din=4'b0110 during SHIFT and during DONE.
   - Response: no reload; original bits complete; exactly one done pulse.
4. Mid-transfer reset:
   - Stimulus: clear=0 after the second shift.
   - Response: immediately busy=0, count=0, par_out=0, no done; the next start behaves like test 1.
5. Serial fill:
   - Stimulus: sin=1, din=4'b0000.
   - Response: par_out=4'b1111 in the DONE cycle.
6. ROTATE_EN build:
   - Stimulus: din=4'b1101, sin=0.
   - Response: sout sequence 1,0,1,1; par_out=4'b1101 in the DONE cycle.
